mux_logic_unit_pipe: RTL
========================

// Module: mux_logic_unit_pipe
// PURPOSE
//  WIDTH-bit bitwise logic unit. Every result bit is a 2:1 mux: A bit selects between two functions of the B bit.
//  Eight opcodes. One registered output stage with a valid/ready handshake.
//  Optional accumulate mode feeds the stored result back as operand A.
//  Saturating delivered-transaction counter. Sits between operand sources and datapath consumers.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=1)
//  CNT_W   16  width of delivered-transaction counter (>=1)
// PORTS
//  Clocking: one clock; reset is synchronous and active-high.
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand set valid
//  in_ready   out  1      unit can accept an operand set this cycle
//  op         in   3      opcode, see BEHAVIOUR
//  acc_en     in   1      use accumulator as operand A and store result into it
//  acc_clr    in   1      synchronous accumulator clear
//  a          in   WIDTH  operand A (mux select per bit)
//  b          in   WIDTH  operand B (mux data per bit)
//  out_valid  out  1      y/flags valid
//  out_ready  in   1      downstream accepts result
//  y          out  WIDTH  registered result
//  zero       out  1      registered: y == 0
//  ones       out  1      registered: y == all ones
//  parity     out  1      registered: XOR-reduce of y
//  acc        out  WIDTH  accumulator contents
//  txn_cnt    out  CNT_W  count of delivered results, saturating
// BEHAVIOUR
//  Opcode, per bit i, with Ai = acc_en ? acc[i] : a[i]:
//   0 AND  : Ai ? b : 0      1 OR   : Ai ? 1 : b
//   2 NAND : Ai ? ~b : 1     3 NOR  : Ai ? 0 : ~b
//   4 XOR  : Ai ? ~b : b     5 XNOR : Ai ? b : ~b
//   6 PASSA: Ai ? 1 : 0      7 PASSB: Ai ? b : b
//  accept = in_valid & in_ready. in_ready = ~out_valid | out_ready (combinational from out_ready).
//  Latency: 1 cycle. On accept, y/zero/ones/parity load at the edge and out_valid=1 the next cycle.
//  out_valid & ~out_ready: y and flags hold stable; in_ready=0.
//  out_valid & out_ready & accept in the same cycle: back-to-back, one result per clock, no bubble.
//  out_valid & out_ready & ~accept: out_valid -> 0. y holds its last value.
//  Accumulator: on accept with acc_en=1, acc <= computed result.
//   acc_clr=1 has priority: acc <= 0. An accept in the same cycle still computes with the pre-clear acc
//   and delivers on y, but the result is not stored in acc.
//   acc_en=0 leaves acc unchanged.
//  txn_cnt: increments on out_valid & out_ready and saturates at 2^CNT_W-1, with no wrap.
//  in_valid=0 ignores op, a, b, acc_en. acc_clr acts regardless of in_valid.
//  Reset (rst=1 at edge): out_valid=0, y=0, zero=1, ones=0, parity=0, acc=0, txn_cnt=0.
//   in_ready=1 on the cycle after reset.
//   Reset mid-transaction discards the pending result and does not count it.
//  WIDTH=1: ones == ~zero, and parity == y.
// STRUCTURE
//  Package mux_logic_pkg: localparams OP_AND..OP_PASSB (3-bit codes 0..7), opcode width constant.
//  Sub-module mux_gate_slice (combinational, 1 bit): inputs sel, d, op; output f.
//   Decodes op into the two mux legs and implements f = sel ? leg1 : leg0.
//  Top: generate loop of WIDTH slices, output register, handshake logic, accumulator, counter.
// TESTING
//  1 Truth table: WIDTH=8, a=8'hF0, b=8'hCC, ops 0..7, out_ready=1.
//    Expect y = C0, FC, 3F, 03, 3C, C3, F0, CC. Flags: zero=0 for all; parity=0 for all eight.
//  2 Backpressure: 3 back-to-back operand sets, out_ready=0 for 4 cycles.
//    Expect first result held; in_ready=0; no loss. Then 3 results in order on consecutive cycles.
//  3 Accumulate: acc_clr, then acc_en=1 XOR with b=8'h0F, 8'hFF, 8'h0F.
//    Expect acc = 0F, F0, FF. Last y has ones=1.
//  4 Clear race: acc=8'hAA, acc_clr=1 with accept OR b=8'h01, acc_en=1.
//    Expect y=AB, acc=00.
//  5 Counter: CNT_W=2, deliver 5 results. Expect txn_cnt 1,2,3,3,3.
//  6 Reset mid-stream: out_valid=1 with out_ready=0, assert rst.
//    Expect out_valid=0, y=0, zero=1, acc=0, txn_cnt=0 next cycle.

Source files
------------

// File: rtl/mux_logic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_logic_pkg : opcode codes and flag bundle for the mux logic unit   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package mux_logic_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_PASSA = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSB = 3'd7;

    typedef struct packed {
        logic zero;
        logic ones;
        logic parity;
    } flags_t;

endpackage : mux_logic_pkg
`default_nettype wire

// File: rtl/mux_gate_slice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_gate_slice : one result bit, f = sel ? leg1 : leg0, legs from op  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mux_gate_slice
    import mux_logic_pkg::*;
(
    input  logic            sel,
    input  logic            d,
    input  logic [OP_W-1:0] op,
    output logic            f
);

    logic w_leg0;
    logic w_leg1;

    always_comb begin
        w_leg0 = 1'b0;
        w_leg1 = 1'b0;
        case (op)
            OP_AND:   begin w_leg1 = d;     w_leg0 = 1'b0;  end
            OP_OR:    begin w_leg1 = 1'b1;  w_leg0 = d;     end
            OP_NAND:  begin w_leg1 = ~d;    w_leg0 = 1'b1;  end
            OP_NOR:   begin w_leg1 = 1'b0;  w_leg0 = ~d;    end
            OP_XOR:   begin w_leg1 = ~d;    w_leg0 = d;     end
            OP_XNOR:  begin w_leg1 = d;     w_leg0 = ~d;    end
            OP_PASSA: begin w_leg1 = 1'b1;  w_leg0 = 1'b0;  end
            OP_PASSB: begin w_leg1 = d;     w_leg0 = d;     end
            default:  begin w_leg1 = 1'b0;  w_leg0 = 1'b0;  end
        endcase
    end

    assign f = sel ? w_leg1 : w_leg0;

endmodule : mux_gate_slice
`default_nettype wire

// File: rtl/mux_logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_logic_unit_pipe : per-bit mux logic unit, registered output with  |
// | valid/ready, accumulator feedback and saturating delivery counter     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module mux_logic_unit_pipe
    import mux_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_en,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] txn_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    flags_t           r_flags;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_deliver;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_res;
    flags_t           w_flags;

    assign in_ready  = ~r_out_valid | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_deliver = r_out_valid & out_ready;
    assign w_opa     = acc_en ? r_acc : a;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_slice
            mux_gate_slice u_slice (
                .sel (w_opa[i]),
                .d   (b[i]),
                .op  (op),
                .f   (w_res[i])
            );
        end
    endgenerate

    assign w_flags.zero   = (w_res == '0);
    assign w_flags.ones   = (w_res == '1);
    assign w_flags.parity = ^w_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_flags     <= '{zero: 1'b1, ones: 1'b0, parity: 1'b0};
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_y         <= w_res;
                r_flags     <= w_flags;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Clear wins over a same-cycle accumulate; the result still goes out on y.
            if (acc_clr) begin
                r_acc <= '0;
            end else if (w_accept && acc_en) begin
                r_acc <= w_res;
            end

            if (w_deliver && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero      = r_flags.zero;
    assign ones      = r_flags.ones;
    assign parity    = r_flags.parity;
    assign acc       = r_acc;
    assign txn_cnt   = r_cnt;

endmodule : mux_logic_unit_pipe
`default_nettype wire
